// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit hex driver for a 7-segment display with frame latching,
// inter-digit blanking gap and optional leading-zero suppression.
module seg7_scan_driver #(
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500,
  parameter int BLANK_LZ   = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [7:0] SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [3:0] AN_OFF  = (ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  logic [CW-1:0] div_cnt_reg;
  logic [1:0]    idx_reg;
  logic [15:0]   shadow_data_reg;
  logic [3:0]    shadow_dp_reg;

  logic          slot_wrap;
  logic          frame_wrap;
  logic          gap;
  logic [3:0]    nib;
  logic [3:0]    upper_zero;
  logic [6:0]    hex_seg;
  logic [7:0]    seg_next;
  logic [3:0]    an_next;

  assign slot_wrap  = (div_cnt_reg == DIV_LAST);
  assign frame_wrap = slot_wrap && (idx_reg == 2'd3);
  assign gap        = (BLANK_CYC > 0) && (int'(div_cnt_reg) < BLANK_CYC);
  assign nib        = shadow_data_reg[4*idx_reg +: 4];

  // upper_zero[i]: nibbles i..3 are all zero, so digit i is a leading zero
  assign upper_zero[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_lz
      assign upper_zero[gi] = (shadow_data_reg[15:4*gi] == '0);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg     <= '0;
      idx_reg         <= 2'd0;
      shadow_data_reg <= 16'h0000;
      shadow_dp_reg   <= 4'h0;
      frame_done      <= 1'b0;
    end else begin
      div_cnt_reg <= slot_wrap ? '0 : div_cnt_reg + 1'b1;
      if (slot_wrap) begin
        idx_reg <= idx_reg + 2'd1;
      end
      if (frame_wrap) begin
        shadow_data_reg <= data_in;
        shadow_dp_reg   <= dp_in;
      end
      frame_done <= frame_wrap;
    end
  end

  always_comb begin
    hex_seg = 7'h00;
    case (nib)
      4'h0: hex_seg = 7'h3F;
      4'h1: hex_seg = 7'h06;
      4'h2: hex_seg = 7'h5B;
      4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66;
      4'h5: hex_seg = 7'h6D;
      4'h6: hex_seg = 7'h7D;
      4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F;
      4'h9: hex_seg = 7'h6F;
      4'hA: hex_seg = 7'h77;
      4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39;
      4'hD: hex_seg = 7'h5E;
      4'hE: hex_seg = 7'h79;
      default: hex_seg = 7'h71;
    endcase
  end

  // Active-high internally; at most one anode set, never two
  always_comb begin
    seg_next = 8'h00;
    an_next  = 4'h0;
    if (en && !gap && !((BLANK_LZ != 0) && upper_zero[idx_reg])) begin
      seg_next = {shadow_dp_reg[idx_reg], hex_seg};
      an_next  = 4'b0001 << idx_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= (ACTIVE_LOW != 0) ? ~seg_next : seg_next;
      an  <= (ACTIVE_LOW != 0) ? ~an_next : an_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=4, BLANK_CYC=1, active-low outputs.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  seg7_scan_driver #(
    .SCAN_DIV(4), .BLANK_CYC(1), .BLANK_LZ(1), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .dp_in(dp_in),
    .seg(seg), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle carrying a frame_done pulse (bounded)
  task automatic sync_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 40);
    check_val("sync_fd", {31'd0, frame_done}, 32'd1);
  endtask

  // Called on the frame_done cycle (j=0). Cycle j reflects state of cycle j-1:
  // slot k covers j=4k+1..4k+4, first cycle is the blanking gap.
  // Expected digit patterns are active-high {dp,gfedcba}.
  task automatic check_frame(input string name,
                             input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3,
                             input logic [3:0] lit,
                             input int chg_j, input logic [15:0] chg_val,
                             input int en_off_j, input int en_on_j);
    logic [7:0] dig [4];
    logic [7:0] es;
    logic [3:0] ea;
    int k, sub;
    int b0;
    b0 = bad;
    dig[0] = d0; dig[1] = d1; dig[2] = d2; dig[3] = d3;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      k   = (j - 1) / 4;
      sub = (j - 1) % 4;
      if (sub != 0 && lit[k] && en) begin
        es = ~dig[k];
        ea = ~(4'b0001 << k);
      end else begin
        es = 8'hFF;
        ea = 4'hF;
      end
      check_val($sformatf("%s_an_j%0d", name, j), {28'd0, an}, {28'd0, ea});
      check_val($sformatf("%s_seg_j%0d", name, j), {24'd0, seg}, {24'd0, es});
      check_val($sformatf("%s_fd_j%0d", name, j), {31'd0, frame_done}, {31'd0, (j == 16)});
      if (j == chg_j) data_in = chg_val;
      if (j == en_off_j) en = 1'b0;
      if (j == en_on_j) en = 1'b1;
    end
    $display("frame %s checked, errors=%0d", name, bad - b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    data_in = 16'h12AF;
    dp_in   = 4'h0;
    #12;
    check_val("rst_seg", {24'd0, seg}, 32'hFF);
    check_val("rst_an", {28'd0, an}, 32'hF);
    check_val("rst_fd", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 12AF: digit0 F, digit1 A, digit2 2, digit3 1
    sync_frame();
    check_frame("h12AF", 8'h71, 8'h77, 8'h5B, 8'h06, 4'b1111, -1, 16'h0, -1, -1);

    // Asynchronous reset while digit 0 is lit
    @(negedge clk);
    @(negedge clk);
    check_val("prerst_an", {28'd0, an}, 32'hE);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_seg", {24'd0, seg}, 32'hFF);
    check_val("async_rst_an", {28'd0, an}, 32'hF);
    check_val("async_rst_fd", {31'd0, frame_done}, 32'd0);
    data_in = 16'h0005;
    dp_in   = 4'hF;
    @(negedge clk);
    check_val("held_rst_an", {28'd0, an}, 32'hF);
    rst_n = 1'b1;

    // Leading zeros blanked, DP of blanked digits suppressed
    sync_frame();
    check_frame("h0005", 8'hED, 8'h00, 8'h00, 8'h00, 4'b0001, -1, 16'h0, -1, -1);

    data_in = 16'h0000;
    dp_in   = 4'b0001;
    sync_frame();
    check_frame("h0000dp", 8'hBF, 8'h00, 8'h00, 8'h00, 4'b0001, -1, 16'h0, -1, -1);

    // Mid-frame data change must not tear the displayed frame
    data_in = 16'h1111;
    dp_in   = 4'h0;
    sync_frame();
    check_frame("h1111", 8'h06, 8'h06, 8'h06, 8'h06, 4'b1111, 6, 16'h2222, -1, -1);
    check_frame("h2222", 8'h5B, 8'h5B, 8'h5B, 8'h5B, 4'b1111, -1, 16'h0, -1, -1);

    // en toggle: dark while low, cadence of frame_done unchanged
    check_frame("en_toggle", 8'h5B, 8'h5B, 8'h5B, 8'h5B, 4'b1111, -1, 16'h0, 3, 9);
    check_frame("en_after", 8'h5B, 8'h5B, 8'h5B, 8'h5B, 4'b1111, -1, 16'h0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
